// File: rtl/instruction_fetch_if.sv
// I-cache read channel between the IF stage and the instruction cache.
// master: fetch side (issues requests); slave: cache side (returns data).
interface instruction_fetch_if;
    logic        icache_read;
    logic [31:0] icache_address;
    logic        icache_resp;
    logic [31:0] icache_rdata;

    modport master (
        output icache_read,
        output icache_address,
        input  icache_resp,
        input  icache_rdata
    );

    modport slave (
        input  icache_read,
        input  icache_address,
        output icache_resp,
        output icache_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// rv32i IF stage: owns the PC, runs a single-outstanding read handshake with the
// I-cache and loads the IF/ID register (PC_out, instruction_out, valid_out).
// Honours downstream stall and EX redirect; wrong-path cache data is never delivered.
// Optional macro IFETCH_STATS_EN adds fetch_count / stall_count perf counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
`ifdef IFETCH_STATS_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    instruction_fetch_if.master   icache,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic [31:0]           PC_out,
    output logic [31:0]           instruction_out,
    output logic                  valid_out
`ifdef IFETCH_STATS_EN
    ,
    output logic [CNT_W-1:0]      fetch_count,
    output logic [CNT_W-1:0]      stall_count
`endif
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    // Fetch: request in flight; Discard: wrong-path request in flight, its data is
    // dropped; Hold: data captured but IF/ID is stalled, no request issued.
    typedef enum logic [1:0] {StFetch, StDiscard, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        load;
    logic [31:0] load_instr;
    logic [31:0] seq_pc;

    assign seq_pc = req_addr_q + 32'd4;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and PC/request-address/hold-buffer updates
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_buf_d = hold_buf_q;
        load       = 1'b0;
        load_instr = icache.icache_rdata;
        case (state_q)
            StFetch: begin
                if (redirect && icache.icache_resp) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                end else if (redirect) begin
                    // Request already on the bus must complete; remember the target.
                    pc_d    = redirect_pc;
                    state_d = StDiscard;
                end else if (icache.icache_resp && stall) begin
                    hold_buf_d = icache.icache_rdata;
                    state_d    = StHold;
                end else if (icache.icache_resp) begin
                    load       = 1'b1;
                    load_instr = icache.icache_rdata;
                    pc_d       = seq_pc;
                    req_addr_d = seq_pc;
                end
            end
            StDiscard: begin
                if (icache.icache_resp) begin
                    // A redirect landing on the drop cycle still wins over the older target.
                    pc_d       = redirect ? redirect_pc : pc_q;
                    req_addr_d = redirect ? redirect_pc : pc_q;
                    state_d    = StFetch;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = StFetch;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = hold_buf_q;
                    pc_d       = seq_pc;
                    req_addr_d = seq_pc;
                    state_d    = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Cache request outputs
    always_comb begin
        icache.icache_read    = !rst && (state_q != StHold);
        icache.icache_address = req_addr_q;
    end

    // IF/ID next value: redirect flushes, stall holds, otherwise load or bubble
    always_comb begin
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
            instr_d = Nop;
        end else if (!stall) begin
            if (load) begin
                pc_out_d = req_addr_q;
                instr_d  = load_instr;
                valid_d  = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_buf_q <= 32'h0;
            pc_out_q   <= 32'h0;
            instr_q    <= Nop;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_buf_q <= hold_buf_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign PC_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

`ifdef IFETCH_STATS_EN
    logic [CNT_W-1:0] fetch_count_q;
    logic [CNT_W-1:0] stall_count_q;

    // Perf counters: delivered instructions and cycles spent waiting on the cache
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (load) begin
                fetch_count_q <= fetch_count_q + 1'b1;
            end
            if (icache.icache_read && !icache.icache_resp) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
